writeback_stage: RTL and testbench

- MEM/WB pipeline register plus result-select and load-extract logic for the 5-stage RV32I core.
- Drives the register-file write port (rd_w -> A3, result_w -> WD3, reg_write_w -> WE3).
- Exports the same three signals to the hazard/forwarding unit.
- Maintains a 64-bit retired-instruction counter.

---
 rtl/core_pkg.sv | 18 +
 rtl/load_extend.sv | 43 ++++
 rtl/writeback_stage.sv | 134 +++++++++++++
 tb/tb_writeback_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I core: result-source select and load funct3 codes.
// Used by the control decoder, the data-memory block and the writeback stage.
package core_pkg;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_MEM  = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_ZERO = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load extraction: selects the byte/half addressed by offset from an
// aligned memory word and sign- or zero-extends it. Misaligned halves use offset[1] only.
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lane selection
  always_comb begin
    byte_s = 8'h00;
    case (offset)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = offset[1] ? word[31:16] : word[15:0];
  end

  // Extension by load type; unknown funct3 passes the whole word
  always_comb begin
    ext = word;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH:   ext = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_s};
      F3_LW:   ext = word;
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result select and load extraction; drives the
// register-file write port and keeps the retired-instruction counter.
module writeback_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_w,
  input  logic             flush_w,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_m,
  input  logic [1:0]       result_src_m,
  input  logic [2:0]       funct3_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus4_m,
  output logic [4:0]       rd_w,
  output logic [XLEN-1:0]  result_w,
  output logic             reg_write_w,
  output logic             valid_w,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q,     valid_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_q,        rd_d;
  logic [1:0]       src_q,       src_d;
  logic [2:0]       funct3_q,    funct3_d;
  logic [XLEN-1:0]  alu_q,       alu_d;
  logic [XLEN-1:0]  data_q,      data_d;
  logic [XLEN-1:0]  pc4_q,       pc4_d;
  logic [CNT_W-1:0] instret_q,   instret_d;

  logic             retire_s;
  logic [XLEN-1:0]  load_ext_s;
  logic [XLEN-1:0]  result_s;

  // Next state of the WB register: flush beats stall, stall holds, else capture
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    src_d       = src_q;
    funct3_d    = funct3_q;
    alu_d       = alu_q;
    data_d      = data_q;
    pc4_d       = pc4_q;
    if (flush_w) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall_w) begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
    end else begin
      valid_d     = valid_m;
      reg_write_d = reg_write_m & valid_m;
      rd_d        = rd_m;
      src_d       = result_src_m;
      funct3_d    = funct3_m;
      alu_d       = alu_result_m;
      data_d      = read_data_m;
      pc4_d       = pc_plus4_m;
    end
  end

  // A valid instruction leaves WB when not stalled, or when flushed out of a stall
  assign retire_s  = valid_q & (~stall_w | flush_w);

  // Retired-instruction counter, wraps silently
  always_comb begin
    if (retire_s) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  // WB pipeline register and counter with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      src_q       <= 2'b00;
      funct3_q    <= 3'b000;
      alu_q       <= {XLEN{1'b0}};
      data_q      <= {XLEN{1'b0}};
      pc4_q       <= {XLEN{1'b0}};
      instret_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      src_q       <= src_d;
      funct3_q    <= funct3_d;
      alu_q       <= alu_d;
      data_q      <= data_d;
      pc4_q       <= pc4_d;
      instret_q   <= instret_d;
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .funct3(funct3_q),
    .offset(alu_q[1:0]),
    .word  (data_q),
    .ext   (load_ext_s)
  );

  // Result select from registered WB fields only
  always_comb begin
    result_s = {XLEN{1'b0}};
    case (src_q)
      RESULT_ALU:  result_s = alu_q;
      RESULT_MEM:  result_s = load_ext_s;
      RESULT_PC4:  result_s = pc4_q;
      RESULT_ZERO: result_s = {XLEN{1'b0}};
      default:     result_s = {XLEN{1'b0}};
    endcase
  end

  assign rd_w        = rd_q;
  assign result_w    = result_s;
  assign reg_write_w = reg_write_q & valid_q & (rd_q != 5'd0);
  assign valid_w     = valid_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage: the driver queues hand-computed
// expectations, a monitor pops one per clock and compares the WB outputs.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, stall_w, flush_w, valid_m, reg_write_m;
  logic [4:0]  rd_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        reg_write_w, valid_w;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
    logic        v;
    logic [63:0] cnt;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  localparam logic [31:0] DATA = 32'h80FF7F01;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .rd_m(rd_m),
    .result_src_m(result_src_m), .funct3_m(funct3_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m),
    .pc_plus4_m(pc_plus4_m), .rd_w(rd_w), .result_w(result_w),
    .reg_write_w(reg_write_w), .valid_w(valid_w), .instret(instret)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, n_step, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled after the active edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      n_step++;
      chk("valid_w", {63'd0, valid_w}, {63'd0, cur.v});
      chk("reg_write_w", {63'd0, reg_write_w}, {63'd0, cur.we});
      chk("instret", instret, cur.cnt);
      if (cur.chk_data) begin
        chk("rd_w", {59'd0, rd_w}, {59'd0, cur.rd});
        chk("result_w", {32'd0, result_w}, {32'd0, cur.res});
      end
    end
  end

  task automatic drive(input logic r, input logic st, input logic fl, input logic v,
                       input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    rst = r; stall_w = st; flush_w = fl; valid_m = v; reg_write_m = rw;
    rd_m = rd; result_src_m = src; funct3_m = f3; alu_result_m = alu;
    read_data_m = DATA; pc_plus4_m = pc4;
  endtask

  task automatic step(input logic r, input logic st, input logic fl, input logic v,
                      input logic rw, input logic [4:0] rd, input logic [1:0] src,
                      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                      input exp_t e);
    @(negedge clk);
    drive(r, st, fl, v, rw, rd, src, f3, alu, pc4);
    exp_q.push_back(e);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0);
    //    rst   stall flush valid rw    rd     src    f3      alu            pc4             exp: rd res we v cnt chk
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b00, 3'b000, 32'h55,   32'h0,   '{5'd0, 32'h0, 1'b0, 1'b0, 64'd0, 1'b1});
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b00, 3'b000, 32'h55,   32'h0,   '{5'd0, 32'h0, 1'b0, 1'b0, 64'd0, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  2'b00, 3'b000, 32'h2A,   32'h0,   '{5'd5, 32'h2A, 1'b1, 1'b1, 64'd0, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b000, 32'h1003, 32'h0,   '{5'd6, 32'hFFFFFF80, 1'b1, 1'b1, 64'd1, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b100, 32'h1003, 32'h0,   '{5'd6, 32'h00000080, 1'b1, 1'b1, 64'd2, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b001, 32'h1002, 32'h0,   '{5'd6, 32'hFFFF80FF, 1'b1, 1'b1, 64'd3, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b001, 32'h1003, 32'h0,   '{5'd6, 32'hFFFF80FF, 1'b1, 1'b1, 64'd4, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b101, 32'h1002, 32'h0,   '{5'd6, 32'h000080FF, 1'b1, 1'b1, 64'd5, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b010, 32'h1003, 32'h0,   '{5'd6, 32'h80FF7F01, 1'b1, 1'b1, 64'd6, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b000, 32'h1000, 32'h0,   '{5'd6, 32'h00000001, 1'b1, 1'b1, 64'd7, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b100, 32'h1001, 32'h0,   '{5'd6, 32'h0000007F, 1'b1, 1'b1, 64'd8, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  2'b00, 3'b000, 32'h99,   32'h0,   '{5'd0, 32'h99, 1'b0, 1'b1, 64'd9, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  2'b10, 3'b000, 32'h77,   32'h104, '{5'd1, 32'h104, 1'b1, 1'b1, 64'd10, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2,  2'b11, 3'b000, 32'h33,   32'h0,   '{5'd2, 32'h0, 1'b1, 1'b1, 64'd11, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  2'b00, 3'b000, 32'h1,    32'h0,   '{5'd3, 32'h1, 1'b0, 1'b0, 64'd12, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  2'b00, 3'b000, 32'h2,    32'h0,   '{5'd4, 32'h2, 1'b0, 1'b1, 64'd12, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  2'b00, 3'b000, 32'hDEAD, 32'h0,   '{5'd9, 32'hDEAD, 1'b1, 1'b1, 64'd13, 1'b1});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'hBEEF, 32'h0, '{5'd9, 32'hDEAD, 1'b1, 1'b1, 64'd13, 1'b1});
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'hBEEF, 32'h0,   '{5'd0, 32'h0, 1'b0, 1'b0, 64'd14, 1'b0});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 2'b00, 3'b000, 32'h11,   32'h0,   '{5'd11, 32'h11, 1'b1, 1'b1, 64'd14, 1'b1});
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h12,   32'h0,   '{5'd0, 32'h0, 1'b0, 1'b0, 64'd15, 1'b0});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h13,   32'h0,   '{5'd13, 32'h13, 1'b1, 1'b1, 64'd15, 1'b1});
    // Counter wrap: preload all-ones just before a retiring edge
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 2'b00, 3'b000, 32'h14, 32'h0);
    force dut.instret_q = {64{1'b1}};
    #1;
    release dut.instret_q;
    exp_q.push_back('{5'd14, 32'h14, 1'b1, 1'b1, 64'd0, 1'b1});
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15, 2'b00, 3'b000, 32'h15,   32'h0,   '{5'd0, 32'h0, 1'b0, 1'b0, 64'd0, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 3'b000, 32'h0,    32'h0,   '{5'd0, 32'h0, 1'b0, 1'b0, 64'd0, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd15, 2'b00, 3'b000, 32'h5A,   32'h0,   '{5'd15, 32'h5A, 1'b1, 1'b1, 64'd0, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 3'b000, 32'h0,    32'h0,   '{5'd0, 32'h0, 1'b0, 1'b0, 64'd1, 1'b1});
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #3;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
